// File: rtl/mul_seq_if.sv
// Start/ready handshake and result bus for mul_seq.
// master: drives start, a, b, mode; observes ready, done, product, tz.
// slave : the multiplier side.
interface mul_seq_if #(
  parameter int unsigned WIDTH = 4
) ();
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             ready;
  logic             done;
  logic [PW-1:0]    product;
  logic [CW-1:0]    tz;

  modport master (
    output start, a, b, mode,
    input  ready, done, product, tz
  );

  modport slave (
    input  start, a, b, mode,
    output ready, done, product, tz
  );
endinterface

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier with a single-cycle shift mode.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mul_seq_if.slave: start/a/b/mode in; ready/done/product/tz out
// mode 0: shift-and-add, one multiplier bit per cycle, done WIDTH cycles
//         after accept. mode 1: product = a << b, done the next cycle.
// tz reports the trailing-zero count of the accepted a (WIDTH when a = 0).
module mul_seq #(
  parameter int unsigned WIDTH = 4
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned CNTW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]     tz_lat_q, tz_lat_d;
  logic [PW-1:0]     product_q, product_d;
  logic [CW-1:0]     tz_q, tz_d;
  logic              done_q, done_d;
  logic [PW-1:0]     acc_sum_c;

  // Trailing-zero count; scanning from the MSB leaves the lowest set bit.
  function automatic logic [CW-1:0] tz_count(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = CW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) n = CW'(i);
    end
    return n;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tz_lat_q  <= '0;
      product_q <= '0;
      tz_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tz_lat_q  <= tz_lat_d;
      product_q <= product_d;
      tz_q      <= tz_d;
      done_q    <= done_d;
    end
  end

  // Accumulator including the current iteration's conditional add.
  assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tz_lat_d  = tz_lat_q;
    product_d = product_q;
    tz_d      = tz_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          tz_lat_d = tz_count(bus.a);
          if (bus.mode) begin
            // Widen before shifting so bits up to PW-1 survive.
            product_d = PW'({{WIDTH{1'b0}}, bus.a} << bus.b);
            tz_d      = tz_count(bus.a);
            done_d    = 1'b1;
          end else begin
            acc_d    = '0;
            mcand_d  = PW'(bus.a);
            mplier_d = bus.b;
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        acc_d    = acc_sum_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = CNTW'(cnt_q + 1'b1);
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          product_d = acc_sum_c;
          tz_d      = tz_lat_q;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.tz      = tz_q;
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: WIDTH=4 directed scenarios and a
// WIDTH=8 randomized sweep against an arithmetic reference model.
module tb_mul_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mul_seq_if #(.WIDTH(4)) b4 ();
  mul_seq_if #(.WIDTH(8)) b8 ();

  mul_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mul_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: trailing zeros counted upward from bit 0.
  function automatic int tz_ref(input int v, input int w);
    int n;
    if (v == 0) return w;
    n = 0;
    while (((v >> n) & 1) == 0) n++;
    return n;
  endfunction

  // Reference: a << b truncated to 2w bits.
  function automatic longint shl_ref(input int av, input int bv, input int w);
    if (bv >= 2 * w) return 0;
    return (longint'(av) << bv) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // One transaction on the selected DUT; lat is the edge index (accept = 0)
  // after which done is first seen, -1 on timeout. rdy_ok drops if ready
  // is seen high in mode 0 before done.
  task automatic do_op(input bit w8, input int av, input int bv, input bit md,
                       output longint prod, output int tzv, output int lat,
                       output bit rdy_ok);
    bit dn, rd;
    @(negedge clk);
    if (w8) begin b8.start = 1'b1; b8.a = 8'(av); b8.b = 8'(bv); b8.mode = md; end
    else    begin b4.start = 1'b1; b4.a = 4'(av); b4.b = 4'(bv); b4.mode = md; end
    @(posedge clk); #1;
    b4.start = 1'b0; b8.start = 1'b0;
    lat = -1; rdy_ok = 1'b1; prod = 0; tzv = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      dn = w8 ? b8.done : b4.done;
      rd = w8 ? b8.ready : b4.ready;
      if (dn) begin
        lat  = k;
        prod = w8 ? longint'(b8.product) : longint'(b4.product);
        tzv  = w8 ? int'(b8.tz) : int'(b4.tz);
        break;
      end
      if (!md && rd) rdy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (b4.ready !== 1'b1 || b4.done !== 1'b0 || b4.product !== 8'd0 || b4.tz !== 3'd0) begin
      errors++;
      $display("FAIL reset4: ready=%b done=%b product=%0d tz=%0d, want 1 0 0 0",
               b4.ready, b4.done, b4.product, b4.tz);
    end
    checks++;
    if (b8.ready !== 1'b1 || b8.done !== 1'b0 || b8.product !== 16'd0 || b8.tz !== 4'd0) begin
      errors++;
      $display("FAIL reset8: ready=%b done=%b product=%0d tz=%0d, want 1 0 0 0",
               b8.ready, b8.done, b8.product, b8.tz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mode0_basic();
    longint p; int t, l; bit r;
    do_op(1'b0, 13, 11, 1'b0, p, t, l, r);
    checks++;
    if (l !== 4) begin errors++; $display("FAIL m0_latency: got %0d want 4", l); end
    checks++;
    if (!r) begin errors++; $display("FAIL m0_ready_low: ready rose before done"); end
    checks++;
    if (b4.ready !== 1'b1) begin errors++; $display("FAIL m0_ready_done: got %b want 1", b4.ready); end
    checks++;
    if (p !== 143 || t !== 0) begin errors++; $display("FAIL m0_13x11: product=%0d tz=%0d want 143 0", p, t); end
    @(posedge clk); #1;
    checks++;
    if (b4.done !== 1'b0) begin errors++; $display("FAIL m0_done_pulse: done=%b want 0", b4.done); end
    checks++;
    if (b4.product !== 8'd143) begin errors++; $display("FAIL m0_hold: product=%0d want 143", b4.product); end
  endtask

  task automatic test_shift();
    longint p; int t, l; bit r;
    // start held for two edges: two results on consecutive cycles
    @(negedge clk);
    b4.start = 1'b1; b4.a = 4'd5; b4.b = 4'd3; b4.mode = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b4.done !== 1'b1 || b4.product !== 8'd40 || b4.tz !== 3'd0) begin
      errors++; $display("FAIL sh_5_3: done=%b product=%0d tz=%0d want 1 40 0", b4.done, b4.product, b4.tz);
    end
    b4.a = 4'd15; b4.b = 4'd7;
    @(posedge clk); #1;
    b4.start = 1'b0;
    checks++;
    if (b4.done !== 1'b1 || b4.product !== 8'd128) begin
      errors++; $display("FAIL sh_15_7: done=%b product=%0d want 1 128", b4.done, b4.product);
    end
    @(posedge clk); #1;
    checks++;
    if (b4.done !== 1'b0) begin errors++; $display("FAIL sh_done_drop: done=%b want 0", b4.done); end
    do_op(1'b0, 15, 9, 1'b1, p, t, l, r);
    checks++;
    if (l !== 0 || p !== 0 || t !== 0) begin
      errors++; $display("FAIL sh_15_9: lat=%0d product=%0d tz=%0d want 0 0 0", l, p, t);
    end
  endtask

  task automatic test_tz_zero();
    longint p; int t, l; bit r;
    do_op(1'b0, 12, 1, 1'b0, p, t, l, r);
    checks++;
    if (l !== 4 || p !== 12 || t !== 2) begin
      errors++; $display("FAIL tz_12x1: lat=%0d product=%0d tz=%0d want 4 12 2", l, p, t);
    end
    do_op(1'b0, 0, 9, 1'b0, p, t, l, r);
    checks++;
    if (l !== 4 || p !== 0 || t !== 4) begin
      errors++; $display("FAIL tz_0x9: lat=%0d product=%0d tz=%0d want 4 0 4", l, p, t);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    b4.start = 1'b1; b4.a = 4'd3; b4.b = 4'd3; b4.mode = 1'b0;
    @(posedge clk); #1;            // accept
    b4.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;            // two cycles into RUN
    b4.start = 1'b1; b4.a = 4'd15; b4.b = 4'd15;
    @(posedge clk); #1;
    b4.start = 1'b0;
    checks++;
    if (b4.ready !== 1'b0 || b4.done !== 1'b0) begin
      errors++; $display("FAIL b2b_busy: ready=%b done=%b want 0 0", b4.ready, b4.done);
    end
    n = 3;
    while (b4.done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 4 || b4.product !== 8'd9 || b4.tz !== 3'd0) begin
      errors++; $display("FAIL b2b_first: lat=%0d product=%0d tz=%0d want 4 9 0", n, b4.product, b4.tz);
    end
    // start in the done cycle
    b4.start = 1'b1; b4.a = 4'd2; b4.b = 4'd7; b4.mode = 1'b0;
    @(posedge clk); #1;
    b4.start = 1'b0;
    checks++;
    if (b4.ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: ready=%b want 0", b4.ready); end
    n = 0;
    while (b4.done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 4 || b4.product !== 8'd14 || b4.tz !== 3'd1) begin
      errors++; $display("FAIL b2b_second: lat=%0d product=%0d tz=%0d want 4 14 1", n, b4.product, b4.tz);
    end
  endtask

  task automatic test_reset_mid();
    longint p; int t, l; bit r, seen;
    @(negedge clk);
    b4.start = 1'b1; b4.a = 4'd15; b4.b = 4'd15; b4.mode = 1'b0;
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (b4.ready !== 1'b1 || b4.done !== 1'b0 || b4.product !== 8'd0 || b4.tz !== 3'd0) begin
      errors++; $display("FAIL rst_mid: ready=%b done=%b product=%0d tz=%0d want 1 0 0 0",
                         b4.ready, b4.done, b4.product, b4.tz);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (b4.done) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_no_done: done=1 want 0"); end
    do_op(1'b0, 6, 7, 1'b0, p, t, l, r);
    checks++;
    if (l !== 4 || p !== 42 || t !== 1) begin
      errors++; $display("FAIL rst_next: lat=%0d product=%0d tz=%0d want 4 42 1", l, p, t);
    end
  endtask

  task automatic test_width8();
    longint p, ep; int t, l, av, bv, el; bit r, md;
    do_op(1'b1, 255, 255, 1'b0, p, t, l, r);
    checks++;
    if (l !== 8 || p !== 65025 || t !== 0 || !r) begin
      errors++; $display("FAIL w8_max: lat=%0d product=%0d tz=%0d rdy=%b want 8 65025 0 1", l, p, t, r);
    end
    for (int i = 0; i < 500; i++) begin
      av = int'($urandom_range(0, 255));
      md = 1'($urandom_range(0, 1));
      bv = md ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      ep = md ? shl_ref(av, bv, 8) : longint'(av) * longint'(bv);
      el = md ? 0 : 8;
      do_op(1'b1, av, bv, md, p, t, l, r);
      checks++;
      if (l !== el) begin errors++; $display("FAIL w8_lat: a=%0d b=%0d mode=%0d got %0d want %0d", av, bv, md, l, el); end
      checks++;
      if (p !== ep) begin errors++; $display("FAIL w8_product: a=%0d b=%0d mode=%0d got %0d want %0d", av, bv, md, p, ep); end
      checks++;
      if (t !== tz_ref(av, 8)) begin errors++; $display("FAIL w8_tz: a=%0d got %0d want %0d", av, t, tz_ref(av, 8)); end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    b4.start = 1'b0; b4.a = '0; b4.b = '0; b4.mode = 1'b0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.mode = 1'b0;
    test_reset();
    test_mode0_basic();
    test_shift();
    test_tz_zero();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
